// File: rtl/onehot_scan_decoder.sv
// N-to-2^N one-hot decoder with registered outputs and a self-running scan mode.
// Define ONEHOT_SCAN_BOUNCE_EN to make the scan ping-pong instead of wrapping.
module onehot_scan_decoder #(
    parameter int N  = 5,
    parameter int PW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic [N-1:0]      sel,
    input  logic              load,
    input  logic [PW-1:0]     period,
    output logic [2**N-1:0]   y,
    output logic [N-1:0]      idx,
    output logic              valid,
    output logic              wrap
);

    localparam int M = 2**N;
    localparam logic [N-1:0]  IDX_ZERO = {N{1'b0}};
    localparam logic [N-1:0]  IDX_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]  IDX_MAX  = {N{1'b1}};
    localparam logic [PW-1:0] PS_ZERO  = {PW{1'b0}};
    localparam logic [PW-1:0] PS_ONE   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [M-1:0]  Y_ONE    = {{(M-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  idx_q, idx_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [M-1:0]  y_q, y_d;
    logic          valid_q, valid_d;
    logic          wrap_q, wrap_d;
`ifdef ONEHOT_SCAN_BOUNCE_EN
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;
    logic          dir_q, dir_d;
`endif

    // Next-state, index, prescaler and output decode
    always_comb begin
        state_d = ST_IDLE;
        idx_d   = IDX_ZERO;
        presc_d = PS_ZERO;
        wrap_d  = 1'b0;
`ifdef ONEHOT_SCAN_BOUNCE_EN
        dir_d   = DIR_UP;
`endif
        if (!en) begin
            state_d = ST_IDLE;
        end else if (!mode) begin
            state_d = ST_DECODE;
            idx_d   = sel;
        end else begin
            state_d = ST_SCAN;
            case (state_q)
                ST_SCAN: begin
                    if (load) begin
                        idx_d = sel;
                    end else if (presc_q >= period) begin
`ifdef ONEHOT_SCAN_BOUNCE_EN
                        // Turn around at either end; dir only changes on a tick
                        dir_d = dir_q;
                        if (dir_q == DIR_UP) begin
                            if (idx_q == IDX_MAX) begin
                                dir_d = DIR_DOWN;
                                idx_d = idx_q - IDX_ONE;
                            end else begin
                                idx_d = idx_q + IDX_ONE;
                            end
                        end else begin
                            if (idx_q == IDX_ZERO) begin
                                dir_d = DIR_UP;
                                idx_d = IDX_ONE;
                            end else begin
                                idx_d = idx_q - IDX_ONE;
                            end
                        end
                        wrap_d = (idx_d == IDX_MAX) || (idx_d == IDX_ZERO);
`else
                        idx_d  = idx_q + IDX_ONE;
                        wrap_d = (idx_d == IDX_ZERO);
`endif
                    end else begin
                        idx_d   = idx_q;
                        presc_d = presc_q + PS_ONE;
`ifdef ONEHOT_SCAN_BOUNCE_EN
                        dir_d   = dir_q;
`endif
                    end
                end
                default: begin
                    idx_d = sel;
                end
            endcase
        end
        valid_d = (state_d != ST_IDLE);
        if (valid_d) begin
            y_d = Y_ONE << idx_d;
        end else begin
            y_d = {M{1'b0}};
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= IDX_ZERO;
            presc_q <= PS_ZERO;
            y_q     <= {M{1'b0}};
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
`ifdef ONEHOT_SCAN_BOUNCE_EN
            dir_q   <= DIR_UP;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            presc_q <= presc_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
`ifdef ONEHOT_SCAN_BOUNCE_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign y     = y_q;
    assign idx   = idx_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed self-checking bench for onehot_scan_decoder (N=5 main instance, N=2 scan instance).
module tb_onehot_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic        en, mode, load;
    logic [4:0]  sel;
    logic [7:0]  period;
    logic [31:0] y;
    logic [4:0]  idx;
    logic        valid, wrap;

    logic        en2, mode2, load2;
    logic [1:0]  sel2;
    logic [3:0]  period2;
    logic [3:0]  y2;
    logic [1:0]  idx2;
    logic        valid2, wrap2;

    int total = 0;
    int bad   = 0;

    onehot_scan_decoder #(.N(5), .PW(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .load(load),
        .period(period), .y(y), .idx(idx), .valid(valid), .wrap(wrap)
    );

    onehot_scan_decoder #(.N(2), .PW(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .mode(mode2), .sel(sel2), .load(load2),
        .period(period2), .y(y2), .idx(idx2), .valid(valid2), .wrap(wrap2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_idx3 [10] = '{30, 30, 30, 31, 31, 31, 0, 0, 0, 1};
        int exp_wr3  [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
`ifdef ONEHOT_SCAN_BOUNCE_EN
        int exp_idx6 [6]  = '{2, 3, 2, 1, 0, 1};
        int exp_wr6  [6]  = '{0, 1, 0, 0, 1, 0};
`else
        int exp_idx6 [6]  = '{2, 3, 0, 1, 2, 3};
        int exp_wr6  [6]  = '{0, 0, 1, 0, 0, 0};
`endif
        rst_n = 1'b0; en = 1'b1; mode = 1'b1; load = 1'b0; sel = 5'd3; period = 8'd0;
        en2 = 1'b0; mode2 = 1'b0; load2 = 1'b0; sel2 = 2'd0; period2 = 4'd0;

        // Reset held for two edges with scan requested
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_y", y, 32'd0);
            chk("rst_idx", {27'd0, idx}, 32'd0);
            chk("rst_valid", {31'd0, valid}, 32'd0);
            chk("rst_wrap", {31'd0, wrap}, 32'd0);
        end

        // DECODE sweep
        rst_n = 1'b1; mode = 1'b0;
        for (int s = 0; s < 32; s++) begin
            sel = 5'(s);
            step();
            chk("dec_y", y, 32'h1 << s);
            chk("dec_valid", {31'd0, valid}, 32'd1);
        end
        en = 1'b0;
        step();
        chk("dis_y", y, 32'd0);
        chk("dis_valid", {31'd0, valid}, 32'd0);

        // SCAN with period 2 across the wrap point
        en = 1'b1; mode = 1'b1; sel = 5'd30; period = 8'd2;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("scan_idx", {27'd0, idx}, 32'(exp_idx3[i]));
            chk("scan_wrap", {31'd0, wrap}, 32'(exp_wr3[i]));
            chk("scan_y", y, 32'h1 << exp_idx3[i]);
        end

        // load coinciding with a tick that would have wrapped
        mode = 1'b0;
        step();
        mode = 1'b1; sel = 5'd31; period = 8'd0;
        step();
        chk("ld_entry_idx", {27'd0, idx}, 32'd31);
        load = 1'b1; sel = 5'd7;
        step();
        chk("ld_idx", {27'd0, idx}, 32'd7);
        chk("ld_wrap", {31'd0, wrap}, 32'd0);
        load = 1'b0;
        step();
        chk("ld_next_idx", {27'd0, idx}, 32'd8);

        // en drop discards the scan; re-entry restarts from sel
        en = 1'b0;
        step();
        chk("drop_valid", {31'd0, valid}, 32'd0);
        en = 1'b1; sel = 5'd5;
        step();
        chk("reent_idx", {27'd0, idx}, 32'd5);

        // Period lowered mid-scan below the running prescaler
        mode = 1'b0;
        step();
        mode = 1'b1; sel = 5'd12; period = 8'd200;
        step();
        for (int i = 0; i < 50; i++) step();
        chk("slow_idx", {27'd0, idx}, 32'd12);
        period = 8'd3;
        step();
        chk("fast_idx", {27'd0, idx}, 32'd13);
        rst_n = 1'b0;
        step();
        chk("mid_rst_y", y, 32'd0);
        chk("mid_rst_idx", {27'd0, idx}, 32'd0);
        chk("mid_rst_valid", {31'd0, valid}, 32'd0);
        rst_n = 1'b1; mode = 1'b0; sel = 5'd9;
        step();
        chk("post_dec_y", y, 32'h200);
        chk("post_dec_idx", {27'd0, idx}, 32'd9);
        chk("post_dec_valid", {31'd0, valid}, 32'd1);
        load = 1'b1; sel = 5'd4;
        step();
        chk("dec_load_ign", {27'd0, idx}, 32'd4);
        load = 1'b0;

        // N=2 scan: wrap or bounce depending on build
        chk("n2_idle_valid", {31'd0, valid2}, 32'd0);
        en2 = 1'b1; mode2 = 1'b1; sel2 = 2'd2; period2 = 4'd0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("n2_idx", {30'd0, idx2}, 32'(exp_idx6[i]));
            chk("n2_wrap", {31'd0, wrap2}, 32'(exp_wr6[i]));
            chk("n2_y", {28'd0, y2}, 32'h1 << exp_idx6[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
